updown_load_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_next_state.sv | 82 ++++++++
 rtl/updown_load_counter.sv | 61 ++++++
 tb/tb_updown_load_counter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Purpose: shared types and defaults for the up/down load counter.
//   COUNTER_WIDTH_DEFAULT : default counter width
//   dir_e                 : count direction encoding of the up_down input
//   op_e                  : operation selected for the next clock edge
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH_DEFAULT = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_RESET = 3'd4
    } op_e;

endpackage : counter_pkg

// File: rtl/counter_next_state.sv
// Purpose: combinational next-state logic for updown_load_counter.
//   Priority decode (reset > load > count > hold) plus wrap/saturate handling.
// Ports:
//   i_count         : current registered count
//   i_data          : parallel load value
//   i_reset         : synchronous reset, active low
//   i_load          : parallel load request
//   i_up_down       : direction, 1 = up, 0 = down
//   i_enable        : count enable
//   o_next_count_c  : count value for the next edge
//   o_next_wrap_c   : wrap flag value for the next edge
// Build option: COUNTER_SATURATE_EN makes counting stop at the limits, and
//   wrap then flags a step that was blocked by the limit.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_up_down,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_next_count_c,
    output logic             o_next_wrap_c
);

    op_e  w_op;
    logic w_at_max;
    logic w_at_min;

    assign w_at_max = (i_count == {WIDTH{1'b1}});
    assign w_at_min = (i_count == {WIDTH{1'b0}});

    // Priority decode of the operation for this edge.
    always_comb begin
        w_op = OP_HOLD;
        if (!i_reset) begin
            w_op = OP_RESET;
        end else if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_enable) begin
            w_op = (dir_e'(i_up_down) == DIR_UP) ? OP_INC : OP_DEC;
        end
    end

    // Next value and wrap flag; wrap is only ever raised by a count step.
    always_comb begin
        o_next_count_c = i_count;
        o_next_wrap_c  = 1'b0;
        case (w_op)
            OP_RESET: begin
                o_next_count_c = '0;
            end
            OP_LOAD: begin
                o_next_count_c = i_data;
            end
            OP_INC: begin
`ifdef COUNTER_SATURATE_EN
                o_next_count_c = w_at_max ? i_count : i_count + WIDTH'(1);
`else
                o_next_count_c = i_count + WIDTH'(1);
`endif
                o_next_wrap_c  = w_at_max;
            end
            OP_DEC: begin
`ifdef COUNTER_SATURATE_EN
                o_next_count_c = w_at_min ? i_count : i_count - WIDTH'(1);
`else
                o_next_count_c = i_count - WIDTH'(1);
`endif
                o_next_wrap_c  = w_at_min;
            end
            default: begin
                o_next_count_c = i_count;
                o_next_wrap_c  = 1'b0;
            end
        endcase
    end

endmodule : counter_next_state

// File: rtl/updown_load_counter.sv
// Purpose: synchronous up/down counter with parallel load, count enable and a
//   registered one-cycle wrap pulse.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous reset, active low
//   data_in  : parallel load value
//   load     : load data_in on the next edge (beats enable)
//   up_down  : 1 = increment, 0 = decrement
//   enable   : count enable
//   data_out : registered count
//   wrap     : registered pulse, high one cycle after a boundary-crossing step
// Build option: COUNTER_SATURATE_EN selects saturating counting (see
//   counter_next_state); default is modulo wrap-around.
module updown_load_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             up_down,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    counter_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .i_count        (r_count),
        .i_data         (data_in),
        .i_reset        (reset),
        .i_load         (load),
        .i_up_down      (up_down),
        .i_enable       (enable),
        .o_next_count_c (w_next_count),
        .o_next_wrap_c  (w_next_wrap)
    );

    // Count and wrap registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign data_out = r_count;
    assign wrap     = r_wrap;

endmodule : updown_load_counter

// File: tb/tb_updown_load_counter.sv
// Directed self-checking bench for updown_load_counter at WIDTH = 4.
module tb_updown_load_counter;

    localparam int unsigned W = 4;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load;
    logic         up_down;
    logic         enable;
    logic [W-1:0] data_out;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    updown_load_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .up_down  (up_down),
        .enable   (enable),
        .data_out (data_out),
        .wrap     (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then check both outputs 1 time unit later.
    task automatic step(input string tag, input logic [W-1:0] exp_q, input logic exp_w);
        @(posedge clk);
        #1;
        checks++;
        assert (data_out === exp_q)
        else begin
            errors++;
            $error("FAIL %s data_out: got %0d expected %0d", tag, data_out, exp_q);
        end
        checks++;
        assert (wrap === exp_w)
        else begin
            errors++;
            $error("FAIL %s wrap: got %0b expected %0b", tag, wrap, exp_w);
        end
    endtask

    initial begin
        // Reset held two edges while load/enable are asserted.
        reset = 1'b0; load = 1'b1; data_in = 4'd9; enable = 1'b1; up_down = 1'b1;
        step("reset_edge1", 4'd0, 1'b0);
        step("reset_edge2", 4'd0, 1'b0);

        // Release with nothing requested: hold at 0.
        reset = 1'b1; load = 1'b0; enable = 1'b0;
        step("release_hold", 4'd0, 1'b0);

        // Load beats enable-count.
        load = 1'b1; data_in = 4'd5; enable = 1'b1; up_down = 1'b1;
        step("load_prio", 4'd5, 1'b0);
        load = 1'b0; data_in = 4'd0;
        step("count_6", 4'd6, 1'b0);
        step("count_7", 4'd7, 1'b0);
        step("count_8", 4'd8, 1'b0);

        // Enable low holds; up_down toggling has no effect.
        load = 1'b1; data_in = 4'd7;
        step("load_7", 4'd7, 1'b0);
        load = 1'b0; enable = 1'b0; up_down = 1'b0;
        step("hold_a", 4'd7, 1'b0);
        up_down = 1'b1;
        step("hold_b", 4'd7, 1'b0);
        up_down = 1'b0;
        step("hold_c", 4'd7, 1'b0);

        // Up through the all-ones boundary.
        load = 1'b1; data_in = 4'd14; up_down = 1'b1;
        step("load_14", 4'd14, 1'b0);
        load = 1'b0; enable = 1'b1;
        step("up_15", 4'd15, 1'b0);
        step("up_wrap", SAT ? 4'd15 : 4'd0, 1'b1);
        step("up_after", SAT ? 4'd15 : 4'd1, SAT ? 1'b1 : 1'b0);

        // Loading boundary values never raises wrap.
        load = 1'b1; data_in = 4'd15;
        step("load_15", 4'd15, 1'b0);
        data_in = 4'd0;
        step("load_0", 4'd0, 1'b0);

        // Down through zero.
        data_in = 4'd1; up_down = 1'b0;
        step("load_1", 4'd1, 1'b0);
        load = 1'b0;
        step("down_0", 4'd0, 1'b0);
        step("down_wrap", SAT ? 4'd0 : 4'd15, 1'b1);
        step("down_after", SAT ? 4'd0 : 4'd14, SAT ? 1'b1 : 1'b0);

        // Enable low right after a wrap pulse clears it.
        enable = 1'b0;
        step("wrap_clear", SAT ? 4'd0 : 4'd14, 1'b0);

        // Mid-count synchronous reset.
        load = 1'b1; data_in = 4'd10; enable = 1'b1; up_down = 1'b1;
        step("load_10", 4'd10, 1'b0);
        load = 1'b0;
        step("count_11", 4'd11, 1'b0);
        reset = 1'b0;
        step("mid_reset", 4'd0, 1'b0);
        reset = 1'b1;
        step("post_reset", 4'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updown_load_counter
